// File: rtl/axi2apb_pkg.sv
// Shared types and defaults for the AXI-to-APB bridge arbiter.
//   state_e  : APB sequencing states
//   owner_e  : which beat engine currently holds the APB port
//   DEF_*    : default slave region map and timeout
//   helpers  : timeout counter width, owner to one-hot {rd,wr}
package axi2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic {
      OWN_WR = 1'b0,
      OWN_RD = 1'b1
   } owner_e;

   localparam logic [31:0] DEF_SLV0_BASE      = 32'h0001_F000;
   localparam logic [31:0] DEF_SLV0_SIZE      = 32'h0000_1000;
   localparam logic [31:0] DEF_SLV1_BASE      = 32'h0002_F000;
   localparam logic [31:0] DEF_SLV1_SIZE      = 32'h0000_1000;
   localparam int          DEF_TIMEOUT_CYCLES = 256;
   localparam int          DEF_TMO_W          = $clog2(DEF_TIMEOUT_CYCLES);

   function automatic int tmo_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   function automatic logic [1:0] owner_onehot(input owner_e o);
      return (o == OWN_RD) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB slave decoder.
//   addr : request address
//   sel  : one-hot slave select {slv1, slv0}
//   miss : address falls in neither region
module apb_addr_decoder
   import axi2apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] SLV0_BASE  = ADDR_WIDTH'(DEF_SLV0_BASE),
   parameter logic [ADDR_WIDTH-1:0] SLV0_SIZE  = ADDR_WIDTH'(DEF_SLV0_SIZE),
   parameter logic [ADDR_WIDTH-1:0] SLV1_BASE  = ADDR_WIDTH'(DEF_SLV1_BASE),
   parameter logic [ADDR_WIDTH-1:0] SLV1_SIZE  = ADDR_WIDTH'(DEF_SLV1_SIZE)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [1:0]            sel,
   output logic                  miss
);

   logic [ADDR_WIDTH-1:0] off0;
   logic [ADDR_WIDTH-1:0] off1;
   logic                  hit0;
   logic                  hit1;

   // Offset compare avoids overflow of base+size at the top of the map.
   assign off0 = addr - SLV0_BASE;
   assign off1 = addr - SLV1_BASE;
   assign hit0 = (addr >= SLV0_BASE) && (off0 < SLV0_SIZE);
   assign hit1 = (addr >= SLV1_BASE) && (off1 < SLV1_SIZE);

   // Slave 0 wins if regions were ever configured to overlap, keeping sel one-hot.
   assign sel  = {hit1 & ~hit0, hit0};
   assign miss = ~(hit0 | hit1);

endmodule

// File: rtl/apb_rw_arbiter.sv
// Shares one APB master port between the write-beat and read-beat engines.
// Round-robin per burst, grant held until the beat flagged last.
//   clk, rst                     : clock, synchronous active-high reset
//   wr_* / rd_*                  : beat request, accept, completion and error
//   paddr/pwdata/pwrite/psel/penable, prdata/pready/pslverr : APB master
//   owner_o                      : current grant {rd,wr}
//
// state  | meaning
// IDLE   | arbitrate, accept one beat, decode address
// SETUP  | APB setup phase, psel up, penable low
// ACCESS | APB access phase, wait for pready or timeout
// RESP   | done/err pulse to owner, lock and fairness update
module apb_rw_arbiter
   import axi2apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] SLV0_BASE      = ADDR_WIDTH'(DEF_SLV0_BASE),
   parameter logic [ADDR_WIDTH-1:0] SLV0_SIZE      = ADDR_WIDTH'(DEF_SLV0_SIZE),
   parameter logic [ADDR_WIDTH-1:0] SLV1_BASE      = ADDR_WIDTH'(DEF_SLV1_BASE),
   parameter logic [ADDR_WIDTH-1:0] SLV1_SIZE      = ADDR_WIDTH'(DEF_SLV1_SIZE),
   parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_last_i,
   output logic                  wr_done_o,
   output logic                  wr_err_o,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  rd_last_i,
   output logic                  rd_done_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_err_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   output logic                  pwrite_o,
   output logic [1:0]            psel_o,
   output logic                  penable_o,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   output logic [1:0]            owner_o
);

   localparam int              TMO_W    = tmo_width(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e          state;
   owner_e          owner_q;
   owner_e          last_served;
   logic            lock;
   logic            last_q;
   logic [TMO_W-1:0] tmo_cnt;

   logic                  grant_wr;
   logic                  grant_rd;
   logic                  accept;
   owner_e                acc_owner;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_last;
   logic [1:0]            dec_sel;
   logic                  dec_miss;
   logic                  acc_finish;
   logic                  acc_err;
   logic [DATA_WIDTH-1:0] acc_rdata;

   // While locked only the burst owner is offered ready; otherwise the
   // requester that was not served last wins a tie.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (lock) begin
         grant_wr = (owner_q == OWN_WR);
         grant_rd = (owner_q == OWN_RD);
      end else if (wr_valid_i && rd_valid_i) begin
         grant_wr = (last_served == OWN_RD);
         grant_rd = (last_served == OWN_WR);
      end else begin
         grant_wr = wr_valid_i;
         grant_rd = rd_valid_i;
      end
   end

   assign wr_ready_o = ~rst & (state == IDLE) & grant_wr;
   assign rd_ready_o = ~rst & (state == IDLE) & grant_rd;
   assign accept     = (wr_ready_o & wr_valid_i) | (rd_ready_o & rd_valid_i);
   assign acc_owner  = grant_rd ? OWN_RD : OWN_WR;
   assign acc_addr   = grant_rd ? rd_addr_i : wr_addr_i;
   assign acc_last   = grant_rd ? rd_last_i : wr_last_i;

   apb_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLV0_BASE  (SLV0_BASE),
      .SLV0_SIZE  (SLV0_SIZE),
      .SLV1_BASE  (SLV1_BASE),
      .SLV1_SIZE  (SLV1_SIZE)
   ) u_dec (
      .addr (acc_addr),
      .sel  (dec_sel),
      .miss (dec_miss)
   );

   // A timeout ends the access as a failed beat with no read data.
   assign acc_finish = pready_i || (tmo_cnt == TMO_LAST);
   assign acc_err    = pready_i ? pslverr_i : 1'b1;
   assign acc_rdata  = (pready_i && !pslverr_i && owner_q == OWN_RD) ? prdata_i : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_q     <= OWN_WR;
         last_served <= OWN_RD;
         lock        <= 1'b0;
         last_q      <= 1'b0;
         tmo_cnt     <= '0;
         owner_o     <= 2'b00;
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pwrite_o    <= 1'b0;
         psel_o      <= 2'b00;
         penable_o   <= 1'b0;
         wr_done_o   <= 1'b0;
         wr_err_o    <= 1'b0;
         rd_done_o   <= 1'b0;
         rd_err_o    <= 1'b0;
         rd_data_o   <= '0;
      end else begin
         // Completion outputs are single-cycle pulses raised on RESP entry.
         wr_done_o <= 1'b0;
         wr_err_o  <= 1'b0;
         rd_done_o <= 1'b0;
         rd_err_o  <= 1'b0;
         rd_data_o <= '0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (accept) begin
                  owner_q <= acc_owner;
                  owner_o <= owner_onehot(acc_owner);
                  last_q  <= acc_last;
                  lock    <= ~acc_last;
                  if (dec_miss) begin
                     state     <= RESP;
                     wr_done_o <= (acc_owner == OWN_WR);
                     wr_err_o  <= (acc_owner == OWN_WR);
                     rd_done_o <= (acc_owner == OWN_RD);
                     rd_err_o  <= (acc_owner == OWN_RD);
                  end else begin
                     state    <= SETUP;
                     psel_o   <= dec_sel;
                     paddr_o  <= acc_addr;
                     pwrite_o <= (acc_owner == OWN_WR);
                     pwdata_o <= (acc_owner == OWN_WR) ? wr_data_i : '0;
                  end
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (acc_finish) begin
                  state     <= RESP;
                  psel_o    <= 2'b00;
                  penable_o <= 1'b0;
                  wr_done_o <= (owner_q == OWN_WR);
                  wr_err_o  <= (owner_q == OWN_WR) & acc_err;
                  rd_done_o <= (owner_q == OWN_RD);
                  rd_err_o  <= (owner_q == OWN_RD) & acc_err;
                  rd_data_o <= acc_rdata;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               // Errors never end a burst early; only the last beat releases it.
               if (last_q) begin
                  lock        <= 1'b0;
                  last_served <= owner_q;
                  owner_o     <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
